// File: rtl/hash_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hash_pkg
// Description : Shared types and constants for the hash sequencer: the
//               sequencer state encoding, default run length, the key
//               constant used by the attached hash core in keyed mode, and
//               the datapath/counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package hash_pkg;

    // Sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Number of hash shift cycles per run when not overridden.
    localparam int unsigned RUN_CYCLES_DEFAULT = 64;

    // Key constant mixed in by the hash core in keyed mode.
    localparam logic [63:0] HASH_KEY = 64'd5;

    // Datapath and counter widths.
    localparam int DIGEST_W   = 64;
    localparam int CNT_W      = 8;
    localparam int MISMATCH_W = 16;

endpackage : hash_pkg
`default_nettype wire

// File: rtl/hash_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hash_sequencer
// Description : Drives an externally instantiated shift-based hash core
//               through one run: latch message/mode/reference, pulse the
//               core's load strobe, wait RUN_CYCLES shift cycles, capture
//               the digest, compare it against the reference and keep a
//               saturating count of mismatching runs.
//
// Ports       : clk              - single clock, rising edge
//               reset            - synchronous, active-high reset
//               start            - run request, accepted in IDLE/DONE only
//               msg              - message word, latched on accepted start
//               mode             - keyed/normal select, latched on start
//               expected         - reference digest, latched on start
//               hash_o           - digest from the hash core
//               hash_i           - message word presented to the hash core
//               hash_load        - registered load strobe to the hash core
//               hash_normal_mode - registered mode to the hash core
//               busy             - high in LOAD, RUN and CAPTURE
//               done             - one-cycle pulse in DONE
//               digest           - captured core state after RUN_CYCLES
//               match            - digest equals latched reference
//               mismatch_count   - saturating count of mismatching runs
//
// Revision    : 1.0 - initial release
// ============================================================================
module hash_sequencer
    import hash_pkg::*;
#(
    parameter int unsigned RUN_CYCLES = RUN_CYCLES_DEFAULT  // legal 1..255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIGEST_W-1:0]   msg,
    input  logic                  mode,
    input  logic [DIGEST_W-1:0]   expected,
    input  logic [DIGEST_W-1:0]   hash_o,
    output logic [DIGEST_W-1:0]   hash_i,
    output logic                  hash_load,
    output logic                  hash_normal_mode,
    output logic                  busy,
    output logic                  done,
    output logic [DIGEST_W-1:0]   digest,
    output logic                  match,
    output logic [MISMATCH_W-1:0] mismatch_count
);

    // ------------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------------
    state_e                state_q,          state_d;
    logic [CNT_W-1:0]      run_cnt_q,        run_cnt_d;
    logic [DIGEST_W-1:0]   hash_i_q,         hash_i_d;
    logic                  mode_q,           mode_d;
    logic [DIGEST_W-1:0]   expected_q,       expected_d;
    logic                  hash_load_q,      hash_load_d;
    logic                  busy_q,           busy_d;
    logic                  done_q,           done_d;
    logic [DIGEST_W-1:0]   digest_q,         digest_d;
    logic                  match_q,          match_d;
    logic [MISMATCH_W-1:0] mismatch_q,       mismatch_d;

    logic                  w_accept;
    logic                  w_hash_eq;

    // Start is honoured only while the sequencer is not mid-run.
    assign w_accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_hash_eq = (hash_o == expected_q);

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        hash_i_d   = hash_i_q;
        mode_d     = mode_q;
        expected_d = expected_q;
        digest_d   = digest_q;
        match_d    = match_q;
        mismatch_d = mismatch_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // The down-counter covers RUN_CYCLES cycles of RUN.
                run_cnt_d = CNT_W'(RUN_CYCLES - 1);
                state_d   = ST_RUN;
            end

            ST_RUN: begin
                if (run_cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    run_cnt_d = run_cnt_q - 1'b1;
                end
            end

            ST_CAPTURE: begin
                // hash_o here is the core state after exactly RUN_CYCLES
                // shifts; the core moves on at this same edge.
                digest_d = hash_o;
                match_d  = w_hash_eq;
                if (!w_hash_eq && (mismatch_q != '1)) begin
                    mismatch_d = mismatch_q + 1'b1;
                end
                state_d = ST_DONE;
            end

            ST_DONE: begin
                state_d = start ? ST_LOAD : ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_accept) begin
            hash_i_d   = msg;
            mode_d     = mode;
            expected_d = expected;
        end

        // Outputs are decoded from the next state so they register in
        // step with the state they belong to. LOAD is only ever entered
        // from IDLE or DONE, where the strobe is low, so the core always
        // sees a clean rising edge.
        hash_load_d = (state_d == ST_LOAD);
        busy_d      = (state_d == ST_LOAD) || (state_d == ST_RUN) ||
                      (state_d == ST_CAPTURE);
        done_d      = (state_d == ST_DONE);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            run_cnt_q   <= '0;
            hash_i_q    <= '0;
            mode_q      <= 1'b0;
            expected_q  <= '0;
            hash_load_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            digest_q    <= '0;
            match_q     <= 1'b0;
            mismatch_q  <= '0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            hash_i_q    <= hash_i_d;
            mode_q      <= mode_d;
            expected_q  <= expected_d;
            hash_load_q <= hash_load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            digest_q    <= digest_d;
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
        end
    end

    assign hash_i           = hash_i_q;
    assign hash_load        = hash_load_q;
    assign hash_normal_mode = mode_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign digest           = digest_q;
    assign match            = match_q;
    assign mismatch_count   = mismatch_q;

endmodule : hash_sequencer
`default_nettype wire

// File: doc/hash_sequencer.md
HASH_SEQUENCER -- requirements
Module: hash_sequencer

Interface
REQ-001 Parameter RUN_CYCLES, default 64, is the number of hash shift cycles per run; legal range 1..255.
REQ-002 Ports are clk, input, 1, the single clock, rising edge; reset is synchronous and active-high.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a run; sampled only when accepted (see REQ-012).
REQ-005 msg  input  64  message word; latched on an accepted start.
REQ-006 mode  input  1  keyed/normal mode select; latched on an accepted start.
REQ-007 expected  input  64  reference digest; latched on an accepted start.
REQ-008 hash_o  input  64  digest output of the attached hash core.
REQ-009 hash_i  output  64  message word presented to the hash core.
REQ-010 hash_load  output  1  load strobe to the hash core, registered.
REQ-011 hash_normal_mode  output  1  mode to the hash core, registered; plus busy (1), done (1), digest (64), match (1) and mismatch_count (16) outputs.

Function
REQ-012 Start SHALL be accepted in IDLE or DONE only; start in any other state SHALL be ignored with no side effect.
REQ-013 FSM states SHALL be IDLE, LOAD, RUN, CAPTURE and DONE.
REQ-014 Accepted start -> LOAD; LOAD -> RUN after 1 cycle; RUN -> CAPTURE after exactly RUN_CYCLES cycles (down-counter RUN_CYCLES-1..0).
REQ-015 CAPTURE -> DONE after 1 cycle; DONE -> IDLE, or -> LOAD if start is asserted in DONE.
REQ-016 hash_load SHALL be high in LOAD only, exactly one cycle per run.
REQ-017 hash_load SHALL be low for at least one cycle before every rise, so that the core's edge detector always fires.
REQ-018 hash_i and hash_normal_mode SHALL carry the latched msg and mode from LOAD through DONE.
REQ-019 digest SHALL register hash_o at the clock edge ending CAPTURE, which is the core state after exactly RUN_CYCLES shifts.
REQ-020 done SHALL be a 1-cycle pulse in DONE, in cycle start+RUN_CYCLES+3; digest and match SHALL be valid from then until the next accepted start's DONE.
REQ-021 match SHALL be set when digest == latched expected, and updated only at the edge ending CAPTURE.
REQ-022 mismatch_count SHALL increment by 1 on each run with match=0, and saturate at 65535.
REQ-023 busy SHALL be high in LOAD, RUN and CAPTURE, and low in IDLE and DONE.

Reset
REQ-024 On reset, the FSM SHALL go to IDLE on the next edge regardless of state, including mid-RUN.
REQ-025 On reset, hash_load, busy, done, match and hash_normal_mode SHALL go to 0, and hash_i, digest and mismatch_count SHALL go to 0.
REQ-026 A run interrupted by reset SHALL NOT update digest, match or mismatch_count.

Structure
REQ-027 Package hash_pkg SHALL hold: the state enum; RUN_CYCLES default; the key constant 64'd5; digest width 64; counter widths 8 and 16.
REQ-028 The block SHALL have no sub-module; the hash core is instantiated beside it by the integrator and by the bench.

Verification
REQ-029 Timing: RUN_CYCLES=64, msg=0, mode=0, expected=0, start at cycle 10 -> hash_load=1 in cycle 11 only; done=1 in cycle 77; digest=0; match=1; mismatch_count=0.
REQ-030 Mismatch: repeat REQ-029 with expected=64'h1 -> match=0 and mismatch_count=1; a third run -> mismatch_count=2.
REQ-031 Keyed mode: mode=1, msg=64'hDEADBEEF_01234567, RUN_CYCLES=64 -> digest equals the bit-accurate hash core model (key 5, 64 shifts); match follows expected.
REQ-032 Ignored start: start pulsed in every cycle from LOAD through CAPTURE -> exactly one hash_load pulse and one done.
REQ-033 Back-to-back runs: start held high across DONE -> LOAD follows DONE directly, hash_load is low for at least one cycle between pulses, and the second digest is correct.
REQ-034 Reset mid-run: reset asserted in RUN cycle 20 -> next cycle all outputs are 0 and state is IDLE; the following run completes normally.
